// File: rtl/step_scheduler.sv
// step_scheduler: plays a loadable table of control words with per-entry dwell,
// repeating passes, and supports start, stop and pause.
module step_scheduler #(
  parameter int DATA_W  = 12,
  parameter int DWELL_W = 8,
  parameter int DEPTH   = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [IDX_W:0]     len,
  input  logic [7:0]         loops,
  output logic [DATA_W-1:0]  data_out,
  output logic [IDX_W-1:0]   step_idx,
  output logic               step_stb,
  output logic               busy,
  output logic               paused,
  output logic               done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [DATA_W-1:0]  r_tab_data  [DEPTH];
  logic [DWELL_W-1:0] r_tab_dwell [DEPTH];
  logic [1:0]         r_state;
  logic [IDX_W:0]     r_len;
  logic [7:0]         r_loops;
  logic [7:0]         r_pass;
  logic [IDX_W-1:0]   r_idx;
  logic [DWELL_W-1:0] r_dwell;
  logic [DATA_W-1:0]  r_data;
  logic               r_stb;
  logic               r_done;
  logic               w_len_ok;
  logic               w_last;
  logic [7:0]         w_pass_n;
  logic               w_fin;
  logic [IDX_W-1:0]   w_nidx;
  always_comb begin
    w_len_ok = len != '0 && len <= (IDX_W+1)'(DEPTH);
    w_last   = {1'b0, r_idx} == r_len - 1'b1;
    w_pass_n = r_pass == 8'hFF ? r_pass : r_pass + 8'd1;
    w_fin    = r_loops != 8'd0 && w_pass_n == r_loops;
    w_nidx   = w_last ? '0 : r_idx + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tab_data[wr_addr]  <= wr_data;
      r_tab_dwell[wr_addr] <= wr_dwell;
    end
  end
  // Leaving HOLD with pause low also takes a dwell step, so a P-cycle pause costs exactly P cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_loops <= '0;
      r_pass  <= '0;
      r_idx   <= '0;
      r_dwell <= '0;
      r_data  <= '0;
      r_stb   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_stb  <= 1'b0;
      r_done <= 1'b0;
      if (stop) begin
        r_state <= IDLE;
        r_data  <= '0;
        r_idx   <= '0;
      end else if (r_state == IDLE) begin
        if (start && w_len_ok) begin
          r_state <= RUN;
          r_len   <= len;
          r_loops <= loops;
          r_pass  <= '0;
          r_idx   <= '0;
          r_data  <= r_tab_data[0];
          r_dwell <= r_tab_dwell[0];
          r_stb   <= 1'b1;
        end
      end else if (pause) begin
        r_state <= HOLD;
      end else begin
        r_state <= RUN;
        if (r_dwell != '0) begin
          r_dwell <= r_dwell - 1'b1;
        end else if (w_last && w_fin) begin
          r_pass  <= w_pass_n;
          r_state <= IDLE;
          r_data  <= '0;
          r_idx   <= '0;
          r_done  <= 1'b1;
        end else begin
          if (w_last) r_pass <= w_pass_n;
          r_idx   <= w_nidx;
          r_data  <= r_tab_data[w_nidx];
          r_dwell <= r_tab_dwell[w_nidx];
          r_stb   <= 1'b1;
        end
      end
    end
  end
  assign data_out = r_data;
  assign step_idx = r_idx;
  assign step_stb = r_stb;
  assign busy     = r_state != IDLE;
  assign paused   = r_state == HOLD;
  assign done     = r_done;
endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler: directed checks of step_scheduler playback, wrap, stop,
// pause, ignored starts, reset and write-while-playing.
module tb_step_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic [7:0]  wr_dwell;
  logic        start;
  logic        stop;
  logic        pause;
  logic [3:0]  len;
  logic [7:0]  loops;
  logic [11:0] data_out;
  logic [2:0]  step_idx;
  logic        step_stb;
  logic        busy;
  logic        paused;
  logic        done;
  int checks = 0;
  int failures = 0;

  step_scheduler dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dwell(wr_dwell), .start(start), .stop(stop), .pause(pause), .len(len),
    .loops(loops), .data_out(data_out), .step_idx(step_idx), .step_stb(step_stb),
    .busy(busy), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [11:0] d, input logic [7:0] dw);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dwell = dw;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [3:0] l, input logic [7:0] lp);
    len = l; loops = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dwell = '0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; len = '0; loops = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_data", data_out, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_stb", step_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_paused", paused, 0);
    chk("rst_done", done, 0);

    // 1: eight single-cycle entries, one pass
    for (int k = 0; k < 8; k++) wr(3'(k), 12'(k + 1), 8'd0);
    go(4'd8, 8'd1);
    for (int k = 0; k < 8; k++) begin
      chk("t1_data", data_out, k + 1);
      chk("t1_stb", step_stb, 1);
      chk("t1_idx", step_idx, k);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_data_end", data_out, 0);
    chk("t1_busy_end", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // 2: single entry, dwell 2, three passes
    wr(3'd0, 12'h841, 8'd2);
    go(4'd1, 8'd3);
    for (int i = 0; i < 9; i++) begin
      chk("t2_data", data_out, 12'h841);
      chk("t2_stb", step_stb, (i % 3 == 0) ? 1 : 0);
      chk("t2_done", done, 0);
      tick();
    end
    chk("t2_done_end", done, 1);
    chk("t2_data_end", data_out, 0);
    tick();

    // 3: infinite loop, then stop mid-dwell
    wr(3'd0, 12'h011, 8'd3);
    wr(3'd1, 12'h022, 8'd3);
    go(4'd2, 8'd0);
    for (int j = 0; j < 42; j++) begin
      chk("t3_data", data_out, ((j / 4) % 2) ? 12'h022 : 12'h011);
      chk("t3_done", done, 0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_data", data_out, 0);
    chk("t3_idx", step_idx, 0);
    chk("t3_done_stop", done, 0);
    tick();
    chk("t3_done_after", done, 0);

    // 4: dwell 4, pause high for 5 cycles from the entry's second cycle
    wr(3'd0, 12'h005, 8'd4);
    wr(3'd1, 12'h006, 8'd0);
    go(4'd2, 8'd1);
    chk("t4_data0", data_out, 12'h005);
    chk("t4_stb0", step_stb, 1);
    tick();
    for (int j = 1; j < 10; j++) begin
      pause = (j <= 5);
      chk("t4_data", data_out, 12'h005);
      chk("t4_idx", step_idx, 0);
      chk("t4_paused", paused, (j >= 2 && j <= 6) ? 1 : 0);
      chk("t4_stb", step_stb, 0);
      tick();
    end
    pause = 1'b0;
    chk("t4_next_data", data_out, 12'h006);
    chk("t4_next_idx", step_idx, 1);
    chk("t4_next_stb", step_stb, 1);
    tick();
    chk("t4_done", done, 1);
    tick();

    // 5: ignored starts, then reset mid-RUN
    go(4'd0, 8'd1);
    chk("t5_len0", busy, 0);
    go(4'd9, 8'd1);
    chk("t5_len9", busy, 0);
    wr(3'd0, 12'h033, 8'd5);
    go(4'd1, 8'd0);
    chk("t5_run_busy", busy, 1);
    chk("t5_run_data", data_out, 12'h033);
    tick();
    go(4'd2, 8'd1);
    chk("t5_restart_busy", busy, 1);
    chk("t5_restart_stb", step_stb, 0);
    chk("t5_restart_data", data_out, 12'h033);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_data", data_out, 0);
    chk("t5_rst_idx", step_idx, 0);
    chk("t5_rst_stb", step_stb, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_paused", paused, 0);
    chk("t5_rst_done", done, 0);

    // 6: rewrite entry 1 while it is playing
    wr(3'd0, 12'h100, 8'd1);
    wr(3'd1, 12'h200, 8'd3);
    go(4'd2, 8'd2);
    chk("t6_c0", data_out, 12'h100);
    tick(); tick();
    chk("t6_c2", data_out, 12'h200);
    chk("t6_c2_stb", step_stb, 1);
    tick();
    wr(3'd1, 12'hABC, 8'd3);
    chk("t6_c4", data_out, 12'h200);
    tick();
    chk("t6_c5", data_out, 12'h200);
    tick();
    chk("t6_c6", data_out, 12'h100);
    chk("t6_c6_stb", step_stb, 1);
    tick(); tick();
    chk("t6_c8", data_out, 12'hABC);
    chk("t6_c8_idx", step_idx, 1);
    chk("t6_c8_stb", step_stb, 1);
    tick(); tick(); tick(); tick();
    chk("t6_done", done, 1);
    chk("t6_end_data", data_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
